load_store_unit: RTL

//  Upstream master for the 256x8 data RAM. Accepts single load/store requests from the
//  CPU core over a valid/ready handshake, sequences the RAM write/read strobes, and

---
 rtl/lsu_pkg.sv | 10 +
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM state encoding and default widths.
package lsu_pkg;
   localparam int LSU_ADDR_W = 8;
   localparam int LSU_DATA_W = 8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;
endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: single-request master for the 256x8 data RAM, hides its 1-cycle read latency.
// Optional address bounds check enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int                ADDR_W     = LSU_ADDR_W,
   parameter int                DATA_W     = LSU_DATA_W,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data
);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              r_we;
   logic              r_oob;
   logic              w_accept;
   logic              w_oob;

   logic              r_req_ready,   w_req_ready_nxt;
   logic              r_rsp_valid,   w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
   logic              r_rsp_err,     w_rsp_err_nxt;
   logic              r_ram_wr_en,   w_ram_wr_en_nxt;
   logic [ADDR_W-1:0] r_ram_wr_addr, w_ram_wr_addr_nxt;
   logic [DATA_W-1:0] r_ram_wr_data, w_ram_wr_data_nxt;
   logic              r_ram_rd_en,   w_ram_rd_en_nxt;
   logic [ADDR_W-1:0] r_ram_rd_addr, w_ram_rd_addr_nxt;

   assign w_accept = req_valid && r_req_ready && (r_state == ST_IDLE);

`ifdef LSU_BOUNDS_CHECK_EN
   assign w_oob = (req_addr > ADDR_LIMIT);
`else
   // Limit is ignored in this build; the AND folds to constant 0.
   assign w_oob = 1'b0 & (req_addr > ADDR_LIMIT);
`endif

   // State register plus the request attributes latched at accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_oob   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_we  <= req_we;
            r_oob <= w_oob;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_ISSUE;
            else          w_state_nxt = ST_IDLE;
         end
         ST_ISSUE: begin
            if (r_we || r_oob) w_state_nxt = ST_RESP;
            else               w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: w_state_nxt = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) w_state_nxt = ST_IDLE;
            else           w_state_nxt = ST_RESP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs. Strobes are launched at
   // the accept edge so they are visible during ISSUE.
   always_comb begin
      w_req_ready_nxt   = r_req_ready;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_err_nxt     = r_rsp_err;
      w_ram_wr_en_nxt   = 1'b0;
      w_ram_wr_addr_nxt = r_ram_wr_addr;
      w_ram_wr_data_nxt = r_ram_wr_data;
      w_ram_rd_en_nxt   = 1'b0;
      w_ram_rd_addr_nxt = r_ram_rd_addr;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_req_ready_nxt = 1'b0;
               if (w_oob) begin
                  w_ram_wr_en_nxt = 1'b0;
               end else if (req_we) begin
                  w_ram_wr_en_nxt   = 1'b1;
                  w_ram_wr_addr_nxt = req_addr;
                  w_ram_wr_data_nxt = req_wdata;
               end else begin
                  w_ram_rd_en_nxt   = 1'b1;
                  w_ram_rd_addr_nxt = req_addr;
               end
            end else begin
               w_req_ready_nxt = r_req_ready;
            end
         end
         ST_ISSUE: begin
            if (r_we || r_oob) begin
               w_rsp_valid_nxt = 1'b1;
               w_rsp_rdata_nxt = {DATA_W{1'b0}};
               w_rsp_err_nxt   = r_oob;
            end else begin
               w_rsp_valid_nxt = r_rsp_valid;
            end
         end
         ST_CAPTURE: begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = ram_rd_data;
            w_rsp_err_nxt   = 1'b0;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_req_ready_nxt = 1'b1;
            end else begin
               w_rsp_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_rsp_valid_nxt = 1'b0;
            w_req_ready_nxt = 1'b1;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= {DATA_W{1'b0}};
         r_rsp_err     <= 1'b0;
         r_ram_wr_en   <= 1'b0;
         r_ram_wr_addr <= {ADDR_W{1'b0}};
         r_ram_wr_data <= {DATA_W{1'b0}};
         r_ram_rd_en   <= 1'b0;
         r_ram_rd_addr <= {ADDR_W{1'b0}};
      end else begin
         r_req_ready   <= w_req_ready_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_ram_wr_en   <= w_ram_wr_en_nxt;
         r_ram_wr_addr <= w_ram_wr_addr_nxt;
         r_ram_wr_data <= w_ram_wr_data_nxt;
         r_ram_rd_en   <= w_ram_rd_en_nxt;
         r_ram_rd_addr <= w_ram_rd_addr_nxt;
      end
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign ram_wr_en   = r_ram_wr_en;
   assign ram_wr_addr = r_ram_wr_addr;
   assign ram_wr_data = r_ram_wr_data;
   assign ram_rd_en   = r_ram_rd_en;
   assign ram_rd_addr = r_ram_rd_addr;

endmodule
